// File: rtl/lsu.sv
// Load/store unit: one dmem transaction per memory op, req/gnt/rvalid
// handshake, byte-lane store replication and load extension.
module lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic [DATA_WIDTH-1:0] load_data_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state;
  logic                  we_q;
  logic                  fault_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wd_q;

  logic                  accept;
  logic                  f3_ok;
  logic                  algn_ok;
  logic                  bad;
  logic [1:0]            ofs;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wd_c;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] ext;

  assign accept = (state == IDLE) && start_i
                  && (MemRead_i || MemWrite_i);

  always_comb begin
    f3_ok = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !MemWrite_i;
      default:                f3_ok = 1'b0;
    endcase
    algn_ok = 1'b1;
    case (funct3_i[1:0])
      2'b01:   algn_ok = !addr_i[0];
      2'b10:   algn_ok = (addr_i[1:0] == 2'b00);
      default: algn_ok = 1'b1;
    endcase
    bad = (MemRead_i && MemWrite_i) || !f3_ok || !algn_ok;
  end

  assign ofs = addr_q[1:0];

  always_comb begin
    be_c = 4'b1111;
    wd_c = wd_q;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00): begin
        be_c = 4'b0001 << ofs;
        wd_c = {4{wd_q[7:0]}};
      end
      (f3_q[1:0] == 2'b01): begin
        be_c = ofs[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{wd_q[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = wd_q;
      end
    endcase
  end

  assign lane = dmem_rdata_i >> {ofs, 3'b000};

  always_comb begin
    ext = lane;
    case (f3_q)
      3'b000: ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001: ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b100: ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101: ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  // Request fields are only driven while a request is outstanding.
  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = dmem_req_o && we_q;
  assign dmem_addr_o  = dmem_req_o ? {addr_q[DATA_WIDTH-1:2], 2'b00}
                                   : '0;
  assign dmem_be_o    = dmem_req_o ? be_c : 4'b0000;
  assign dmem_wdata_o = dmem_we_o ? wd_c : '0;
  assign stall_o      = (state == REQ) || (state == WAIT) || accept;
  assign done_o       = (state == DONE);
  assign fault_o      = (state == DONE) && fault_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wd_q        <= '0;
      load_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            fault_q <= bad;
            we_q    <= MemWrite_i;
            f3_q    <= funct3_i;
            addr_q  <= addr_i;
            wd_q    <= store_data_i;
            state   <= bad ? DONE : REQ;
          end
        end
        REQ: begin
          if (dmem_gnt_i) state <= we_q ? DONE : WAIT;
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            load_data_o <= ext;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: directed cases plus random ops checked
// against an arithmetic model of addressing, lanes and timing.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        req;
  logic        we;
  logic [31:0] dmem_addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] load_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ld_model = 32'h0;

  always #5 clk = ~clk;

  lsu #(.DATA_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .MemRead_i    (mem_read),
    .MemWrite_i   (mem_write),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .store_data_i (store_data),
    .dmem_req_o   (req),
    .dmem_we_o    (we),
    .dmem_addr_o  (dmem_addr),
    .dmem_be_o    (be),
    .dmem_wdata_o (wdata),
    .dmem_gnt_i   (gnt),
    .dmem_rvalid_i(rvalid),
    .dmem_rdata_i (rdata),
    .stall_o      (stall),
    .done_o       (done),
    .fault_o      (fault),
    .load_data_o  (load_data)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    start      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    rdata      = $urandom;
  endtask

  // Garbage on the start side while busy must be ignored.
  task automatic noise();
    start      = 1'($urandom % 2);
    mem_read   = 1'($urandom % 2);
    mem_write  = 1'($urandom % 2);
    funct3     = 3'($urandom % 8);
    addr       = $urandom;
    store_data = $urandom;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    rdata      = $urandom;
  endtask

  task automatic op(input bit rd, input bit wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input int gw, input int rw,
                    input logic [31:0] rdw);
    int          nb;
    int          o;
    bit          legal;
    logic [31:0] eb;
    logic [31:0] ew;
    logic [31:0] el;
    logic [31:0] lane;
    logic [31:0] mask;
    nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o  = int'(a % 4);
    if (rd && wr) legal = 1'b0;
    else if (rd) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else legal = f3 inside {3'd0, 3'd1, 3'd2};
    if ((a % nb) != 0) legal = 1'b0;
    eb = ((32'd1 << nb) - 32'd1) << o;
    if (nb == 1) ew = {24'h0, wd[7:0]} * 32'h01010101;
    else if (nb == 2) ew = {16'h0, wd[15:0]} * 32'h00010001;
    else ew = wd;
    lane = rdw >> (8 * o);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    el = lane & mask;
    if (!f3[2] && nb < 4 && lane[8*nb-1]) el = el | ~mask;

    @(negedge clk);
    idle_in();
    start      = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = wd;
    rvalid     = 1'($urandom % 2);
    #1;
    check("stall_start", stall, 32'(rd | wr));
    check("req_start", req, 0);
    check("done_start", done, 0);
    if (!rd && !wr) begin
      @(negedge clk);
      idle_in();
      #1;
      check("none_req", req, 0);
      check("none_done", done, 0);
      return;
    end
    if (!legal) begin
      @(negedge clk);
      noise();
      #1;
      check("flt_done", done, 1);
      check("flt_fault", fault, 1);
      check("flt_req", req, 0);
      check("flt_stall", stall, 0);
      check("flt_ld", load_data, ld_model);
      return;
    end
    for (int i = 0; i <= gw; i++) begin
      @(negedge clk);
      noise();
      gnt = (i == gw);
      #1;
      check("req", req, 1);
      check("req_we", we, 32'(wr));
      check("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
      check("req_be", be, eb);
      check("req_wdata", wdata, wr ? ew : 32'h0);
      check("req_stall", stall, 1);
      check("req_done", done, 0);
    end
    if (wr) begin
      @(negedge clk);
      noise();
      #1;
      check("st_done", done, 1);
      check("st_fault", fault, 0);
      check("st_stall", stall, 0);
      check("st_req", req, 0);
      check("st_ld", load_data, ld_model);
      return;
    end
    for (int j = 0; j <= rw; j++) begin
      @(negedge clk);
      noise();
      rvalid = (j == rw);
      rdata  = (j == rw) ? rdw : $urandom;
      #1;
      check("wt_stall", stall, 1);
      check("wt_req", req, 0);
      check("wt_done", done, 0);
    end
    @(negedge clk);
    noise();
    #1;
    check("ld_done", done, 1);
    check("ld_fault", fault, 0);
    check("ld_stall", stall, 0);
    check("ld_data", load_data, el);
    ld_model = el;
  endtask

  task automatic reset_in_wait();
    @(negedge clk);
    idle_in();
    start    = 1'b1;
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h100;
    @(negedge clk);
    idle_in();
    gnt = 1'b1;
    @(negedge clk);
    idle_in();
    rst = 1'b1;
    #1;
    check("rw_stall", stall, 1);
    @(negedge clk);
    rst    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hCAFE_F00D;
    #1;
    check("rw_req", req, 0);
    check("rw_done", done, 0);
    check("rw_stall0", stall, 0);
    check("rw_ld", load_data, 0);
    @(negedge clk);
    idle_in();
    #1;
    check("rw_done2", done, 0);
    check("rw_ld2", load_data, 0);
    ld_model = 32'h0;
  endtask

  initial begin
    bit          rd;
    bit          wr;
    int          r;
    logic [2:0]  f3;
    logic [31:0] a;
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req", req, 0);
    check("rst_we", we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", be, 0);
    check("rst_wdata", wdata, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_ld", load_data, 0);
    rst = 1'b0;

    op(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    check("tp_lw", load_data, 32'hDEAD_BEEF);
    op(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
    check("tp_lb", load_data, 32'hFFFF_FF80);
    op(1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
    check("tp_lbu", load_data, 32'h0000_0080);
    op(1, 0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80FF_0000);
    check("tp_lhu", load_data, 32'h0000_80FF);
    op(0, 1, 3'b000, 32'h101, 32'h1234_5678, 0, 0, 32'h0);
    op(0, 1, 3'b001, 32'h102, 32'h1234_5678, 0, 0, 32'h0);
    op(0, 1, 3'b010, 32'h200, 32'hA5A5_0F0F, 3, 0, 32'h0);
    op(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h1111_1111);
    check("tp_flt_ld", load_data, 32'h0000_80FF);
    op(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h1111_1111);
    reset_in_wait();
    op(1, 0, 3'b010, 32'h104, 32'h0, 1, 2, 32'h0BAD_CAFE);
    check("tp_lw_after", load_data, 32'h0BAD_CAFE);

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom % 10);
      rd = 1'b0;
      wr = 1'b0;
      if (r == 0) begin
        rd = 1'b0;
        wr = 1'b0;
      end else if (r == 1) begin
        rd = 1'b1;
        wr = 1'b1;
      end else if (r < 6) rd = 1'b1;
      else wr = 1'b1;
      f3 = 3'($urandom % 8);
      if ($urandom % 2 == 0) f3 = {f3[2] & rd, 1'b0, 1'b0} | 3'($urandom % 3);
      a = $urandom;
      if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
      op(rd, wr, f3, a, $urandom, int'($urandom % 4),
         int'($urandom % 4), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
